// File: rtl/parity_pkg.sv
// Shared definitions for the streaming parity frame generator: FSM state
// encoding and the parity helper used by both the block and its bench.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TRAIL = 2'd2
    } state_t;

    // Operands narrower than 64 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational XOR-reduction of a WIDTH-bit word to its even-parity bit.
module parity_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_par
);

    assign o_par = ^i_data;

endmodule

// File: rtl/parity_frame_gen.sv
// Streaming parity generator: per-beat parity plus a column-parity trailer per frame.
// Optional build macro PARITY_ERR_INJ_EN adds the err_inj port for parity fault injection.
module parity_frame_gen
    import parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PARITY_ERR_INJ_EN
    input  logic             err_inj,
`endif
    input  logic             odd_mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_par,
    output logic             m_trailer,
    output logic             m_last
);

    localparam int             CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(FRAME_LEN);

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_frame_odd;
    logic               r_m_valid;
    logic [WIDTH-1:0]   r_m_data;
    logic               r_m_par;
    logic               r_m_trailer;
    logic               r_m_last;

    logic               w_out_free;
    logic               w_accept;
    logic               w_odd;
    logic               w_inj;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_close;
    logic [WIDTH-1:0]   w_next_data;
    logic               w_red;
    logic               w_par;

    assign w_out_free = !r_m_valid || m_ready;
    assign s_ready    = w_out_free && (r_state != TRAIL);
    assign w_accept   = s_valid && s_ready;

`ifdef PARITY_ERR_INJ_EN
    assign w_inj = err_inj;
`else
    assign w_inj = 1'b0;
`endif

    // The first beat of a frame takes its polarity straight from odd_mode.
    always_comb begin
        w_odd       = (r_state == IDLE) ? odd_mode : r_frame_odd;
        w_cnt_next  = (r_state == IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
        w_close     = s_last || (w_cnt_next == LEN_C);
        w_next_data = (r_state == TRAIL) ? (r_acc ^ {WIDTH{r_frame_odd}}) : s_data;
    end

    parity_reduce #(.WIDTH(WIDTH)) u_reduce (
        .i_data (w_next_data),
        .o_par  (w_red)
    );

    assign w_par = parity_of(64'(w_red), w_odd) ^ w_inj;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_frame_odd <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_par     <= 1'b0;
            r_m_trailer <= 1'b0;
            r_m_last    <= 1'b0;
        end else if (w_out_free) begin
            if (r_state == TRAIL) begin
                r_m_valid   <= 1'b1;
                r_m_data    <= w_next_data;
                r_m_par     <= w_par;
                r_m_trailer <= 1'b1;
                r_m_last    <= 1'b1;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_state     <= IDLE;
            end else if (w_accept) begin
                r_m_valid   <= 1'b1;
                r_m_data    <= w_next_data;
                r_m_par     <= w_par;
                r_m_trailer <= 1'b0;
                r_m_last    <= 1'b0;
                r_cnt       <= w_cnt_next;
                r_state     <= w_close ? TRAIL : DATA;
                if (r_state == IDLE) begin
                    r_frame_odd <= odd_mode;
                    r_acc       <= s_data;
                end else begin
                    r_acc       <= r_acc ^ s_data;
                end
            end else begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_par     = r_m_par;
    assign m_trailer = r_m_trailer;
    assign m_last    = r_m_last;

endmodule

// File: tb/tb_parity_frame_gen.sv
// Directed self-checking bench for parity_frame_gen with WIDTH=8, FRAME_LEN=4.
// Output beats are logged as {last, trailer, par, data} and compared against hand-built lists.
module tb_parity_frame_gen;
    import parity_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       err_inj;
    logic       odd_mode;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_par;
    logic       m_trailer;
    logic       m_last;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    parity_frame_gen #(.WIDTH(8), .FRAME_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PARITY_ERR_INJ_EN
        .err_inj   (err_inj),
`endif
        .odd_mode  (odd_mode),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_par     (m_par),
        .m_trailer (m_trailer),
        .m_last    (m_last)
    );

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready)
            obs_q.push_back({21'd0, m_last, m_trailer, m_par, m_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_q(input string tag);
        int n;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] hold_data;
        logic       hold_par;

        rst = 1'b1; err_inj = 1'b0; odd_mode = 1'b0; s_valid = 1'b0;
        s_data = 8'h00; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        chk("rst_m_data",    32'(m_data),    32'd0);
        chk("rst_m_par",     32'(m_par),     32'd0);
        chk("rst_m_trailer", 32'(m_trailer), 32'd0);
        chk("rst_m_last",    32'(m_last),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Test 1: even parity, full-length frame.
        send(8'h01, 1'b0); send(8'h03, 1'b0); send(8'h07, 1'b0); send(8'h0F, 1'b0);
        @(negedge clk);
        chk("t1_trail_s_ready", 32'(s_ready), 32'd0);
        exp_q = '{32'h101, 32'h003, 32'h107, 32'h00F, 32'h60A};
        check_q("t1");

        // Test 2: odd parity; a mid-frame odd_mode change must not affect the frame.
        odd_mode = 1'b1;
        send(8'h01, 1'b0);
        odd_mode = 1'b0;
        send(8'h03, 1'b0); send(8'h07, 1'b0); send(8'h0F, 1'b0);
        exp_q = '{32'h001, 32'h103, 32'h007, 32'h10F, 32'h7F5};
        check_q("t2");

        // Test 3: early close with s_last, then a full frame to show the count restarted.
        send(8'hAA, 1'b0); send(8'h55, 1'b1);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h04, 1'b0); send(8'h08, 1'b0);
        exp_q = '{32'h0AA, 32'h055, 32'h6FF, 32'h101, 32'h102, 32'h104, 32'h108, 32'h60F};
        check_q("t3");

        // Test 4: three cycles of backpressure while the second beat is pending.
        send(8'h11, 1'b0); send(8'h22, 1'b0);
        m_ready  = 1'b0;
        s_valid  = 1'b1;
        s_data   = 8'h44;
        hold_data = m_data;
        hold_par  = m_par;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t4_hold_valid%0d", i), 32'(m_valid), 32'd1);
            chk($sformatf("t4_hold_data%0d", i),  32'(m_data),  32'(hold_data));
            chk($sformatf("t4_hold_par%0d", i),   32'(m_par),   32'(hold_par));
            chk($sformatf("t4_s_ready%0d", i),    32'(s_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(8'h44, 1'b0); send(8'h88, 1'b0);
        exp_q = '{{23'd0, parity_of(64'h11, 1'b0), 8'h11},
                  {23'd0, parity_of(64'h22, 1'b0), 8'h22},
                  32'h044, 32'h088, 32'h6FF};
        check_q("t4");

        // Test 5: reset after two beats drops the partial frame and the pending beat.
        send(8'hAA, 1'b0); send(8'hBB, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t5_rst_m_data",  32'(m_data),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h04, 1'b0); send(8'h08, 1'b0);
        exp_q = '{32'h0AA, 32'h101, 32'h102, 32'h104, 32'h108, 32'h60F};
        check_q("t5");

`ifdef PARITY_ERR_INJ_EN
        // Test 6: inject a parity error on the second beat only.
        send(8'h01, 1'b0);
        err_inj = 1'b1;
        send(8'h03, 1'b0);
        err_inj = 1'b0;
        send(8'h07, 1'b0); send(8'h0F, 1'b0);
        exp_q = '{32'h101, 32'h103, 32'h107, 32'h00F, 32'h60A};
        check_q("t6");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
